// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter for SRL/SRA/SRLV/SRAV: coarse steps of BIG_STEP bits,
// then single-bit steps, with a one-cycle done pulse when the result is ready.
module shift_right_seq #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int BIG_STEP = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_W-1:0] BIG_AMT = SHAMT_W'(BIG_STEP);
    localparam logic [SHAMT_W-1:0] ONE_AMT = SHAMT_W'(1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   shreg_reg, shreg_next;
    logic [SHAMT_W-1:0] rem_reg, rem_next;
    logic               fill_reg, fill_next;
    logic [WIDTH-1:0]   big_shift;
    logic [WIDTH-1:0]   one_shift;

    // Vacated positions take the fill bit captured at accept, not the current MSB.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi + BIG_STEP < WIDTH) begin : g_big_src
                assign big_shift[gi] = shreg_reg[gi+BIG_STEP];
            end else begin : g_big_fill
                assign big_shift[gi] = fill_reg;
            end
            if (gi + 1 < WIDTH) begin : g_one_src
                assign one_shift[gi] = shreg_reg[gi+1];
            end else begin : g_one_fill
                assign one_shift[gi] = fill_reg;
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        rem_next   = rem_reg;
        fill_next  = fill_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    shreg_next = data_in;
                    rem_next   = shamt;
                    fill_next  = arith & data_in[WIDTH-1];
                    state_next = (shamt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                if (rem_reg >= BIG_AMT) begin
                    shreg_next = big_shift;
                    rem_next   = rem_reg - BIG_AMT;
                end else begin
                    shreg_next = one_shift;
                    rem_next   = rem_reg - ONE_AMT;
                end
                if (rem_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            rem_reg   <= '0;
            fill_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            rem_reg   <= rem_next;
            fill_reg  <= fill_next;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    assign result = shreg_reg;

endmodule

// File: tb/tb_shift_right_seq.sv
// Directed vector table plus hand-written multi-cycle sequences for shift_right_seq,
// followed by random operands checked against the >> / >>> operators.
module tb_shift_right_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        arith;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int failures = 0;

    shift_right_seq #(.WIDTH(32), .SHAMT_W(5), .BIG_STEP(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .arith   (arith),
        .busy    (busy),
        .done    (done),
        .result  (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  s;
        logic        a;
        logic [31:0] exp;
        string       name;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One full operation: accept, wait for done with a cycle budget, check
    // latency/result, then check the pulse drops and the result is held.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic a,
                          input logic [31:0] exp, input string name, input bit verbose);
        int cyc;
        int n;
        n = int'(s) / 16 + int'(s) % 16;
        data_in = d;
        shamt   = s;
        arith   = a;
        start   = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        data_in = ~d;
        shamt   = ~s;
        arith   = ~a;
        chk({name, " busy_after_accept"}, 32'(busy), 32'(1));
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " done_seen"}, 32'(done), 32'(1));
        chk({name, " latency"}, 32'(cyc), 32'(n + 1));
        chk({name, " result"}, result, exp);
        @(posedge clk); #1;
        chk({name, " single_pulse"}, 32'(done), 32'(0));
        chk({name, " idle_after"}, 32'(busy), 32'(0));
        chk({name, " result_held"}, result, exp);
        if (verbose)
            $display("op %s d=%08h s=%0d a=%0d result=%08h cycles=%0d", name, d, s, a, result, cyc);
    endtask

    vec_t vecs[12];

    initial begin
        int cyc;
        int pulses;
        logic [31:0]        rd;
        logic signed [31:0] sd;
        logic [4:0]         rs;
        logic               ra;
        logic [31:0]        rexp;

        vecs[0]  = '{32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, "lsr_msb_31"};
        vecs[1]  = '{32'h8000_0000, 5'd4,  1'b1, 32'hF800_0000, "asr_neg_4"};
        vecs[2]  = '{32'h7000_0000, 5'd4,  1'b1, 32'h0700_0000, "asr_pos_4"};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  1'b0, 32'hDEAD_BEEF, "shamt_zero"};
        vecs[4]  = '{32'h1234_5678, 5'd16, 1'b0, 32'h0000_1234, "lsr_16"};
        vecs[5]  = '{32'hFFFF_0000, 5'd16, 1'b1, 32'hFFFF_FFFF, "asr_16"};
        vecs[6]  = '{32'hF000_000F, 5'd8,  1'b1, 32'hFFF0_0000, "asr_8"};
        vecs[7]  = '{32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, "asr_31"};
        vecs[8]  = '{32'hF0F0_F0F0, 5'd17, 1'b0, 32'h0000_7878, "lsr_17"};
        vecs[9]  = '{32'hF0F0_F0F0, 5'd17, 1'b1, 32'hFFFF_F878, "asr_17"};
        vecs[10] = '{32'h1234_5678, 5'd1,  1'b1, 32'h091A_2B3C, "asr_pos_1"};
        vecs[11] = '{32'hA5A5_A5A5, 5'd15, 1'b0, 32'h0001_4B4B, "lsr_15"};

        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = 32'hFFFF_FFFF;
        shamt   = 5'd3;
        arith   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'(0));
        chk("reset done", 32'(done), 32'(0));
        chk("reset result", result, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle no start result", result, 32'h0);

        foreach (vecs[i])
            run_op(vecs[i].d, vecs[i].s, vecs[i].a, vecs[i].exp, vecs[i].name, 1'b1);

        // start held high through an op; inputs change mid-op; back-to-back accept.
        data_in = 32'h8000_0000;
        shamt   = 5'd4;
        arith   = 1'b1;
        start   = 1'b1;
        @(posedge clk); #1;
        data_in = 32'h1234_5678;
        shamt   = 5'd31;
        arith   = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("hold done_seen", 32'(done), 32'(1));
        chk("hold latency", 32'(cyc), 32'(5));
        chk("hold result", result, 32'hF800_0000);
        $display("op hold_start result=%08h cycles=%0d", result, cyc);
        data_in = 32'h00FF_0000;
        shamt   = 5'd16;
        arith   = 1'b0;
        @(posedge clk); #1;
        chk("hold no_second_pulse", 32'(done), 32'(0));
        chk("hold idle_after_done", 32'(busy), 32'(0));
        chk("hold result_kept", result, 32'hF800_0000);
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b busy_after_accept", 32'(busy), 32'(1));
        cyc = 1;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b done_seen", 32'(done), 32'(1));
        chk("b2b latency", 32'(cyc), 32'(2));
        chk("b2b result", result, 32'h0000_00FF);
        $display("op back_to_back result=%08h cycles=%0d", result, cyc);
        @(posedge clk); #1;
        chk("b2b single_pulse", 32'(done), 32'(0));

        // Reset in the middle of a shift aborts without a done pulse.
        data_in = 32'h1234_5678;
        shamt   = 5'd20;
        arith   = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("abort busy_mid_shift", 32'(busy), 32'(1));
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("abort busy", 32'(busy), 32'(0));
        chk("abort done", 32'(done), 32'(0));
        chk("abort result", result, 32'h0);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        chk("abort no_done_pulse", 32'(pulses), 32'(0));
        $display("op reset_abort result=%08h pulses=%0d", result, pulses);
        run_op(32'hF000_000F, 5'd8, 1'b1, 32'hFFF0_0000, "after_abort", 1'b1);

        for (int r = 0; r < 2000; r++) begin
            rd = $urandom;
            rs = 5'($urandom_range(0, 31));
            ra = 1'($urandom_range(0, 1));
            sd = rd;
            if (ra)
                rexp = sd >>> rs;
            else
                rexp = rd >> rs;
            run_op(rd, rs, ra, rexp, "random", 1'b0);
        end
        $display("random ops=2000 done");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
